// File: rtl/dct_pkg.sv
// Shared types and default sizes for the DCT datapath: one row of signed
// coefficients as carried between butterfly stages and between passes.
package dct_pkg;

    localparam int DCT_COEF_W = 10;
    localparam int DCT_LANES  = 8;

    typedef logic signed [DCT_COEF_W-1:0] dct_coef_t;
    typedef dct_coef_t [DCT_LANES-1:0]    dct_row_t;

endpackage

// File: rtl/dct_lane_pipe_if.sv
// Row stream plus pipe control between a DCT producer, the elastic pipe and
// its consumer. The master side drives beats in and takes them out.
interface dct_lane_pipe_if
    import dct_pkg::*;
#(
    parameter int WIDTH = DCT_COEF_W,
    parameter int LANES = DCT_LANES,
    parameter int DEPTH = 2
) ();

    localparam int OCC_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_last;
    logic [OCC_W-1:0]       occupancy;

    modport master (
        output flush, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, occupancy
    );

endinterface

// File: rtl/dct_pipe_stage.sv
// One elastic pipe slot {valid, data, last}. It takes its source whenever the
// slot is open; payload is only written when a real beat arrives.
module dct_pipe_stage
    import dct_pkg::*;
#(
    parameter int DW = DCT_COEF_W * DCT_LANES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          accept,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    input  logic          src_last,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last
);

    // NOTE: state uses non-blocking assignments so every stage samples its
    // neighbour's pre-edge value; the payload is cleared on reset because the
    // output port must read zero, while flush only drops valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
                last <= src_last;
            end
        end
    end

endmodule

// File: rtl/dct_lane_pipe.sv
// Elastic multi-lane row pipe: DEPTH slots with bubble collapse, a ready chain
// that is combinational from out_ready back to in_ready, flush and occupancy.
module dct_lane_pipe
    import dct_pkg::*;
#(
    parameter int WIDTH = DCT_COEF_W,
    parameter int LANES = DCT_LANES,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    dct_lane_pipe_if.slave bus
);

    localparam int DW    = LANES * WIDTH;
    localparam int OCC_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dct_lane_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0]         stage_v;
    logic [DEPTH-1:0]         stage_last;
    logic [DEPTH-1:0][DW-1:0] stage_data;
    logic [DEPTH:0]           open;
    logic                     in_fire;
    logic                     out_fire;
    logic [OCC_W-1:0]         occ_q;

    // NOTE: open gets a full default before the loop so no bit can infer a latch.
    // A slot is open when empty or when its content moves on this same edge.
    always_comb begin
        open        = '0;
        open[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            open[k] = !stage_v[k] || open[k+1];
        end
    end

    assign bus.in_ready = rst && !bus.flush && open[0];
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = stage_v[DEPTH-1] && bus.out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          src_valid;
        logic [DW-1:0] src_data;
        logic          src_last;

        if (k == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_data  = bus.in_data;
            assign src_last  = bus.in_last;
        end else begin : g_chain
            assign src_valid = stage_v[k-1];
            assign src_data  = stage_data[k-1];
            assign src_last  = stage_last[k-1];
        end

        dct_pipe_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .accept    (open[k]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .src_last  (src_last),
            .valid     (stage_v[k]),
            .data      (stage_data[k]),
            .last      (stage_last[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (bus.flush) begin
            occ_q <= '0;
        end else if (in_fire && !out_fire) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign bus.out_valid = stage_v[DEPTH-1];
    assign bus.out_data  = stage_data[DEPTH-1];
    assign bus.out_last  = stage_last[DEPTH-1];
    assign bus.occupancy = occ_q;

endmodule
